vedic_mac_accumulator: RTL and testbench



---
 rtl/vedic_mac_pkg.sv | 13 +
 rtl/multiply_8to8.sv | 30 +++
 rtl/vedic_mac_accumulator.sv | 124 ++++++++++++
 tb/tb_vedic_mac_accumulator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_mac_pkg.sv
// Shared definitions for the Vedic multiply-accumulate stage: FSM encoding and datapath widths.
package vedic_mac_pkg;

  localparam int OPERAND_W = 8;
  localparam int PROD_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/multiply_8to8.sv
// Combinational 8x8 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier built from four 4x4 partial products.
module multiply_8to8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] c
);

  logic [7:0]  pp_ll;
  logic [7:0]  pp_lh;
  logic [7:0]  pp_hl;
  logic [7:0]  pp_hh;
  logic [8:0]  cross_sum;
  logic [15:0] sum_low;
  logic [15:0] sum_cross;
  logic [15:0] sum_high;

  assign pp_ll = a[3:0] * b[3:0];
  assign pp_lh = a[3:0] * b[7:4];
  assign pp_hl = a[7:4] * b[3:0];
  assign pp_hh = a[7:4] * b[7:4];

  // Vertical and crosswise terms combined at their nibble weights
  assign cross_sum = {1'b0, pp_lh} + {1'b0, pp_hl};
  assign sum_low   = {8'h00, pp_ll};
  assign sum_cross = {3'b000, cross_sum, 4'h0};
  assign sum_high  = {pp_hh, 8'h00};

  assign c = sum_low + sum_cross + sum_high;

endmodule

// File: rtl/vedic_mac_accumulator.sv
// Flow-controlled multiply-accumulate around multiply_8to8; define VEDIC_MAC_SATURATE_EN to clamp on overflow instead of wrapping.
module vedic_mac_accumulator
  import vedic_mac_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     acc_out,
  output logic                 overflow,
  output logic                 busy
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              prod_v_q, prod_v_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;

  logic [PROD_W-1:0] mult_c;
  logic              accept;
  logic [ACC_W:0]    prod_ext;
  logic [ACC_W:0]    sum_w;

  multiply_8to8 u_mult (
    .a (a),
    .b (b),
    .c (mult_c)
  );

  assign in_ready = (state_q == ACCUM) && (rem_q != '0);
  assign accept   = in_ready && in_valid;
  assign prod_ext = (ACC_W + 1)'(prod_q);
  // Extra MSB captures the carry out of the accumulator
  assign sum_w    = {1'b0, acc_q} + prod_ext;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    prod_d   = prod_q;
    prod_v_d = prod_v_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          ovf_d    = 1'b0;
          prod_v_d = 1'b0;
          if (len != '0) begin
            rem_d   = len;
            state_d = ACCUM;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        if (prod_v_q) begin
          acc_d = sum_w[ACC_W-1:0];
          if (sum_w[ACC_W]) begin
            ovf_d = 1'b1;
`ifdef VEDIC_MAC_SATURATE_EN
            acc_d = '1;
`else
            acc_d = sum_w[ACC_W-1:0];
`endif
          end
        end
        // The product register refills in the same cycle it drains, so accepts can run back to back
        if (accept) begin
          prod_d   = mult_c;
          prod_v_d = 1'b1;
          rem_d    = rem_q - 1'b1;
        end else begin
          prod_v_d = 1'b0;
        end
        if ((rem_q == '0) && prod_v_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// Self-checking bench: directed and random jobs on a 24-bit and a 16-bit accumulator instance, checked against a sum-of-products model.
module tb_vedic_mac_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [23:0] acc_out;
  logic        overflow;
  logic        busy;

  logic        in_ready16;
  logic        out_valid16;
  logic [15:0] acc_out16;
  logic        overflow16;
  logic        busy16;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int op_a [16];
  int op_b [16];

  vedic_mac_accumulator #(.ACC_W(24), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  vedic_mac_accumulator #(.ACC_W(16), .LEN_W(8)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready16),
    .a         (a),
    .b         (b),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .acc_out   (acc_out16),
    .overflow  (overflow16),
    .busy      (busy16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the job result is just the arithmetic sum of all products, folded into W bits
  function automatic longint model_acc(input longint sum, input int w);
    longint max_v;
    max_v = (longint'(1) << w) - 1;
    if (sum <= max_v) return sum;
`ifdef VEDIC_MAC_SATURATE_EN
    return max_v;
`else
    return sum % (longint'(1) << w);
`endif
  endfunction

  function automatic logic model_ovf(input longint sum, input int w);
    return sum > ((longint'(1) << w) - 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1;
    len   = 8'(n);
    step();
    start = 1'b0;
  endtask

  task automatic feed(input string tag, input int va, input int vb, input int gap);
    int t;
    repeat (gap) step();
    t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) chk({tag, ".in_ready_timeout"}, 64'(in_ready), 64'd1);
    a        = 8'(va);
    b        = 8'(vb);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_job(input string tag, input int n, input int gap, input int stall);
    longint sum;
    logic [23:0] held;
    sum = 0;
    for (int i = 0; i < n; i++) sum += longint'(op_a[i] * op_b[i]);
    pulse_start(n);
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    chk({tag, ".in_ready"}, 64'(in_ready), (n == 0) ? 64'd0 : 64'd1);
    for (int i = 0; i < n; i++) feed(tag, op_a[i], op_b[i], gap);
    if (n > 0) begin
      chk({tag, ".valid_early"}, 64'(out_valid), 64'd0);
      step();
    end
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".acc24"}, 64'(acc_out), 64'(model_acc(sum, 24)));
    chk({tag, ".ovf24"}, 64'(overflow), 64'(model_ovf(sum, 24)));
    chk({tag, ".out_valid16"}, 64'(out_valid16), 64'd1);
    chk({tag, ".acc16"}, 64'(acc_out16), 64'(model_acc(sum, 16)));
    chk({tag, ".ovf16"}, 64'(overflow16), 64'(model_ovf(sum, 16)));
    held = acc_out;
    for (int s = 0; s < stall; s++) begin
      step();
      chk({tag, ".stall_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".stall_acc"}, 64'(acc_out), 64'(held));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
    $display("job %s len=%0d sum=%0d acc24=%0h acc16=%0h ovf16=%0b", tag, n, sum, acc_out, acc_out16, overflow16);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;

    #12;
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.acc", 64'(acc_out), 64'd0);
    chk("rst.ovf", 64'(overflow), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    op_a[0] = 10;  op_b[0] = 20;
    op_a[1] = 17;  op_b[1] = 11;
    op_a[2] = 255; op_b[2] = 255;
    run_job("dot3", 3, 0, 0);

    op_a[0] = 255; op_b[0] = 255;
    op_a[1] = 255; op_b[1] = 255;
    run_job("wrap2", 2, 0, 0);

    run_job("len0", 0, 0, 0);

    op_a[0] = 10; op_b[0] = 20;
    op_a[1] = 17; op_b[1] = 11;
    run_job("gaps", 2, 3, 5);

    // Reset mid-job drops everything without a clock edge
    pulse_start(3);
    feed("rstjob", 9, 9, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", 64'(in_ready), 64'd0);
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.acc", 64'(acc_out), 64'd0);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.busy16", 64'(busy16), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    op_a[0] = 2; op_b[0] = 3;
    run_job("after_rst", 1, 0, 0);

    // start pulses while busy must be ignored
    pulse_start(2);
    feed("ign", 10, 20, 0);
    pulse_start(5);
    chk("ign.in_ready", 64'(in_ready), 64'd1);
    feed("ign", 17, 11, 0);
    step();
    chk("ign.out_valid", 64'(out_valid), 64'd1);
    pulse_start(1);
    chk("ign.done_valid", 64'(out_valid), 64'd1);
    chk("ign.done_acc", 64'(acc_out), 64'd387);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("ign.idle", 64'(busy), 64'd0);

    for (int j = 0; j < 8; j++) begin
      int n;
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        op_a[i] = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
        op_b[i] = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      end
      run_job($sformatf("rnd%0d", j), n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
